pipe_stage_skid_reg: RTL and testbench

//  Parametrised pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, ...).

---
 rtl/pipe_stage_skid_reg_if.sv | 12 +
 rtl/pipe_stage_skid_reg.sv | 134 +++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready/data handshake bundle for one side of a pipeline stage boundary.
// The master drives valid and data; the slave drives ready.
interface pipe_stage_skid_reg_if #(
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer, a fully registered in_ready and a synchronous flush to a bubble.
// Optional perf counters (stall_cycles_o, flush_drops_o) are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid_reg #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int                CNT_W      = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  pipe_stage_skid_reg_if.slave  in_if,
  pipe_stage_skid_reg_if.master out_if
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles_o,
  output logic [CNT_W-1:0]      flush_drops_o
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              out_valid;
  logic              in_ready;
  logic              accept;
  logic              emit;

  // Handshake outputs decode from the state register only, never from in_valid/out_ready.
  assign out_valid    = (state_q != ST_EMPTY);
  assign in_ready     = (state_q != ST_FULL);
  assign accept       = in_if.valid & in_ready;
  assign emit         = out_valid & out_if.ready;
  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = main_q;

  // Stage FSM: main always holds the head entry, skid holds the second one when FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else if (flush_i) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_q <= ST_ONE;
            main_q  <= in_if.data;
          end else begin
            state_q <= ST_EMPTY;
          end
        end
        ST_ONE: begin
          case ({accept, emit})
            2'b11: main_q <= in_if.data;
            2'b10: begin
              state_q <= ST_FULL;
              skid_q  <= in_if.data;
            end
            2'b01: state_q <= ST_EMPTY;
            default: state_q <= ST_ONE;
          endcase
        end
        ST_FULL: begin
          if (emit) begin
            state_q <= ST_ONE;
            main_q  <= skid_q;
          end else begin
            state_q <= ST_FULL;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          main_q  <= BUBBLE_VAL;
          skid_q  <= BUBBLE_VAL;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;
  logic [CNT_W-1:0] drops_q;
  logic [CNT_W-1:0] drops_d;

  // Saturating counters; flush does not clear them, only rst does.
  always_comb begin
    stall_d = stall_q;
    drops_d = drops_q;
    if (out_valid && !out_if.ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end
    if (flush_i && out_valid && (drops_q != CNT_MAX)) begin
      drops_d = drops_q + CNT_ONE;
    end else begin
      drops_d = drops_q;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= {CNT_W{1'b0}};
      drops_q <= {CNT_W{1'b0}};
    end else begin
      stall_q <= stall_d;
      drops_q <= drops_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_drops_o  = drops_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: directed scenarios plus random traffic against a 2-deep FIFO model.
// Define PIPE_STAGE_PERF_EN to also exercise the perf counters.
module tb_pipe_stage_skid_reg;
  localparam int            DW  = 16;
  localparam logic [DW-1:0] BUB = 16'hB0B0;
`ifdef PIPE_STAGE_PERF_EN
  localparam int            CW   = 4;
  localparam int            CMAX = 15;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;

  pipe_stage_skid_reg_if #(.DATA_W(DW)) up_if ();
  pipe_stage_skid_reg_if #(.DATA_W(DW)) dn_if ();

`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_drops;
  int            m_stall;
  int            m_drops;
`endif

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_last;

  pipe_stage_skid_reg #(
    .DATA_W(DW),
    .BUBBLE_VAL(BUB)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .CNT_W(CW)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush_i(flush),
    .in_if(up_if),
    .out_if(dn_if)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cycles_o(stall_cycles),
    .flush_drops_o(flush_drops)
`endif
  );

  always #5 clk = ~clk;

  // Model: a FIFO of capacity 2; the output shows the head, or the last value that left (bubble after reset/flush).
  function automatic logic [DW-1:0] exp_data();
    return (m_q.size() > 0) ? m_q[0] : m_last;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_last = BUB;
`ifdef PIPE_STAGE_PERF_EN
    m_stall = 0;
    m_drops = 0;
`endif
  endfunction

  // Drive one cycle of inputs (starting just after a negedge), update the model at the edge, end at the next negedge.
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
    bit acc;
    bit em;
    up_if.valid = iv;
    up_if.data  = id;
    dn_if.ready = ordy;
    flush       = fl;
    @(posedge clk);
    acc = iv && (m_q.size() < 2);
    em  = (m_q.size() > 0) && ordy;
`ifdef PIPE_STAGE_PERF_EN
    if ((m_q.size() > 0) && !ordy && (m_stall < CMAX)) m_stall++;
    if (fl && (m_q.size() > 0) && (m_drops < CMAX)) m_drops++;
`endif
    if (fl) begin
      m_q.delete();
      m_last = BUB;
    end else begin
      if (em) m_last = m_q.pop_front();
      if (acc) m_q.push_back(id);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++; if (dn_if.valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", dn_if.valid); end
    total++; if (up_if.ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", up_if.ready); end
    total++; if (dn_if.data !== BUB) begin bad++; $display("FAIL reset_out_data got=%h exp=%h", dn_if.data, BUB); end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 16'h00A1, 1'b0, 1'b0);
    step(1'b1, 16'h00B2, 1'b0, 1'b0);
    total++; if (up_if.ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", up_if.ready); end
    total++; if (dn_if.data !== 16'h00A1) begin bad++; $display("FAIL full_out_data got=%h exp=00a1", dn_if.data); end
    // Asynchronous reset in the middle of a cycle while FULL.
    #2 rst = 1'b1;
    #1;
    total++; if (dn_if.valid !== 1'b0) begin bad++; $display("FAIL midreset_out_valid got=%b exp=0", dn_if.valid); end
    total++; if (up_if.ready !== 1'b1) begin bad++; $display("FAIL midreset_in_ready got=%b exp=1", up_if.ready); end
    total++; if (dn_if.data !== BUB) begin bad++; $display("FAIL midreset_out_data got=%h exp=%h", dn_if.data, BUB); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_streaming();
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, DW'(k), 1'b1, 1'b0);
      total++; if (dn_if.data !== DW'(k)) begin bad++; $display("FAIL stream_data got=%h exp=%h", dn_if.data, DW'(k)); end
      total++; if (dn_if.valid !== 1'b1) begin bad++; $display("FAIL stream_valid got=%b exp=1", dn_if.valid); end
      total++; if (up_if.ready !== 1'b1) begin bad++; $display("FAIL stream_ready got=%b exp=1", up_if.ready); end
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    total++; if (dn_if.valid !== 1'b0) begin bad++; $display("FAIL stream_drain_valid got=%b exp=0", dn_if.valid); end
    total++; if (dn_if.data !== exp_data()) begin bad++; $display("FAIL stream_drain_data got=%h exp=%h", dn_if.data, exp_data()); end
  endtask

  task automatic test_back_pressure();
    step(1'b1, 16'h0AAA, 1'b0, 1'b0);
    step(1'b1, 16'h0BBB, 1'b0, 1'b0);
    total++; if (up_if.ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", up_if.ready); end
    step(1'b1, 16'h0CCC, 1'b0, 1'b0);
    total++; if (dn_if.data !== 16'h0AAA) begin bad++; $display("FAIL bp_hold_data got=%h exp=0aaa", dn_if.data); end
    step(1'b1, 16'h0CCC, 1'b1, 1'b0);
    total++; if (dn_if.data !== 16'h0BBB) begin bad++; $display("FAIL bp_second_data got=%h exp=0bbb", dn_if.data); end
    total++; if (up_if.ready !== 1'b1) begin bad++; $display("FAIL bp_second_ready got=%b exp=1", up_if.ready); end
    step(1'b1, 16'h0CCC, 1'b1, 1'b0);
    total++; if (dn_if.data !== 16'h0CCC) begin bad++; $display("FAIL bp_third_data got=%h exp=0ccc", dn_if.data); end
    total++; if (dn_if.valid !== 1'b1) begin bad++; $display("FAIL bp_third_valid got=%b exp=1", dn_if.valid); end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    total++; if (dn_if.valid !== 1'b0) begin bad++; $display("FAIL bp_empty_valid got=%b exp=0", dn_if.valid); end
  endtask

  task automatic test_flush();
    step(1'b1, 16'h00D1, 1'b0, 1'b0);
    step(1'b1, 16'h00D2, 1'b0, 1'b0);
    step(1'b1, 16'h00D3, 1'b0, 1'b1);
    total++; if (dn_if.valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", dn_if.valid); end
    total++; if (up_if.ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", up_if.ready); end
    total++; if (dn_if.data !== BUB) begin bad++; $display("FAIL flush_data got=%h exp=%h", dn_if.data, BUB); end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    total++; if (dn_if.valid !== 1'b0) begin bad++; $display("FAIL flush_discard_valid got=%b exp=0", dn_if.valid); end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    #2 rst = 1'b1;
    #1;
    total++; if (stall_cycles !== 4'd0) begin bad++; $display("FAIL perf_rst_stall got=%0d exp=0", stall_cycles); end
    total++; if (flush_drops !== 4'd0) begin bad++; $display("FAIL perf_rst_drops got=%0d exp=0", flush_drops); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 16'h0E0E, 1'b0, 1'b0);
    repeat (5) step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b1);
    total++; if (stall_cycles !== 4'd5) begin bad++; $display("FAIL perf_stall got=%0d exp=5", stall_cycles); end
    total++; if (flush_drops !== 4'd1) begin bad++; $display("FAIL perf_drops got=%0d exp=1", flush_drops); end
    step(1'b1, 16'h0F0F, 1'b0, 1'b0);
    repeat (20) step(1'b0, 16'h0000, 1'b0, 1'b0);
    total++; if (stall_cycles !== 4'hF) begin bad++; $display("FAIL perf_stall_sat got=%0d exp=15", stall_cycles); end
    repeat (20) begin
      step(1'b1, 16'h0123, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b1);
    end
    total++; if (flush_drops !== 4'hF) begin bad++; $display("FAIL perf_drops_sat got=%0d exp=15", flush_drops); end
    total++; if (stall_cycles !== 4'hF) begin bad++; $display("FAIL perf_stall_hold got=%0d exp=15", stall_cycles); end
  endtask
`endif

  task automatic test_random();
    logic          iv;
    logic          ordy;
    logic          fl;
    logic [DW-1:0] id;
    for (int n = 0; n < 10000; n++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 99) == 0);
      id   = DW'($urandom);
      step(iv, id, ordy, fl);
      total++; if (dn_if.valid !== (m_q.size() > 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, dn_if.valid, m_q.size() > 0); end
      total++; if (up_if.ready !== (m_q.size() < 2)) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", n, up_if.ready, m_q.size() < 2); end
      total++; if (dn_if.data !== exp_data()) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", n, dn_if.data, exp_data()); end
`ifdef PIPE_STAGE_PERF_EN
      total++; if (stall_cycles !== CW'(m_stall)) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", n, stall_cycles, m_stall); end
      total++; if (flush_drops !== CW'(m_drops)) begin bad++; $display("FAIL rnd_drops cyc=%0d got=%0d exp=%0d", n, flush_drops, m_drops); end
`endif
      // Toggling out_ready within the cycle must not move in_ready.
      dn_if.ready = ~dn_if.ready;
      up_if.valid = ~up_if.valid;
      #1;
      total++; if (up_if.ready !== (m_q.size() < 2)) begin bad++; $display("FAIL rnd_ready_indep cyc=%0d got=%b exp=%b", n, up_if.ready, m_q.size() < 2); end
    end
  endtask

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
